// File: rtl/winewhite_bnn_sched_pkg.sv
// Shared definitions for the winewhite BNN request scheduler: dataset defaults
// and the scheduler FSM encoding.
package bnn_sched_pkg;

    localparam int FEAT_CNT_DEF   = 11;
    localparam int FEAT_BITS_DEF  = 4;
    localparam int CLASS_CNT_DEF  = 7;
    localparam int REQ_CNT_DEF    = 2;
    localparam int SETTLE_CYC_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } sched_state_e;

    // Counter width able to hold SETTLE_CYC-1, never narrower than one bit.
    function automatic int settle_cnt_bits(input int settle_cyc);
        return (settle_cyc > 1) ? $clog2(settle_cyc) : 1;
    endfunction

endpackage

// File: rtl/winewhite_bnn_sched_if.sv
// Request/response/core bus of the winewhite BNN scheduler; the block side uses
// the slave modport, requesters/consumer/core use the master modport.
interface winewhite_bnn_sched_if
    import bnn_sched_pkg::*;
#(
    parameter int REQ_CNT   = REQ_CNT_DEF,
    parameter int FEAT_CNT  = FEAT_CNT_DEF,
    parameter int FEAT_BITS = FEAT_BITS_DEF,
    parameter int CLASS_CNT = CLASS_CNT_DEF
);
    localparam int VW = FEAT_CNT * FEAT_BITS;
    localparam int CW = $clog2(CLASS_CNT);
    localparam int IW = $clog2(REQ_CNT);

    logic [REQ_CNT-1:0]    req_valid;
    logic [REQ_CNT-1:0]    req_ready;
    logic [REQ_CNT*VW-1:0] req_features;
    logic [VW-1:0]         core_features;
    logic [CW-1:0]         core_prediction;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IW-1:0]         resp_id;
    logic [CW-1:0]         resp_class;
    logic [15:0]           done_cnt;

    modport slave (
        input  req_valid, req_features, core_prediction, resp_ready,
        output req_ready, core_features, resp_valid, resp_id, resp_class, done_cnt
    );

    modport master (
        output req_valid, req_features, core_prediction, resp_ready,
        input  req_ready, core_features, resp_valid, resp_id, resp_class, done_cnt
    );

endinterface

// File: rtl/winewhite_bnn_sched_rr_arbiter.sv
// Round-robin selector: picks the first active request scanning upward from
// the requester after last_grant, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned and no latch is inferred.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int off = 1; off <= N; off++) begin
            if (!any && req[(int'(last_grant) + off) % N]) begin
                any = 1'b1;
                idx = IW'((int'(last_grant) + off) % N);
                grant[(int'(last_grant) + off) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/winewhite_bnn_sched.sv
// Schedules vectors from several requesters onto one external combinational
// BNN core: accept one, let the core settle, hold the result until consumed.
module winewhite_bnn_sched
    import bnn_sched_pkg::*;
#(
    parameter int FEAT_CNT   = FEAT_CNT_DEF,
    parameter int FEAT_BITS  = FEAT_BITS_DEF,
    parameter int CLASS_CNT  = CLASS_CNT_DEF,
    parameter int REQ_CNT    = REQ_CNT_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    winewhite_bnn_sched_if.slave bus
);
    localparam int VW   = FEAT_CNT * FEAT_BITS;
    localparam int CW   = $clog2(CLASS_CNT);
    localparam int IW   = $clog2(REQ_CNT);
    localparam int CNTW = settle_cnt_bits(SETTLE_CYC);

    sched_state_e    state_q, state_d;
    logic [CNTW-1:0] cnt_q;
    logic [IW-1:0]   last_grant_q;
    logic [VW-1:0]   core_features_q;
    logic            resp_valid_q;
    logic [IW-1:0]   resp_id_q;
    logic [CW-1:0]   resp_class_q;
    logic [15:0]     done_cnt_q;

    logic [REQ_CNT-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic [REQ_CNT-1:0] req_ready_d;
    logic               accept;
    logic               capture;
    logic               handshake;

    rr_arbiter #(
        .N  (REQ_CNT),
        .IW (IW)
    ) u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .idx        (arb_idx),
        .any        (arb_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The grant is only offered while idle and out of reset, so a requester
    // that drops valid before this point simply never gets picked.
    always_comb begin
        state_d     = state_q;
        req_ready_d = '0;
        accept      = 1'b0;
        capture     = 1'b0;
        handshake   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any && !rst) begin
                    req_ready_d = arb_grant;
                    accept      = 1'b1;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.resp_ready) begin
                    handshake = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register reading the
        // pre-edge values of the others, independent of statement order.
        if (rst) begin
            cnt_q           <= '0;
            last_grant_q    <= IW'(REQ_CNT - 1);
            core_features_q <= '0;
            resp_valid_q    <= 1'b0;
            resp_id_q       <= '0;
            resp_class_q    <= '0;
            done_cnt_q      <= '0;
        end else begin
            if (accept) begin
                core_features_q <= bus.req_features[int'(arb_idx)*VW +: VW];
                resp_id_q       <= arb_idx;
                last_grant_q    <= arb_idx;
                cnt_q           <= CNTW'(SETTLE_CYC - 1);
            end else if (state_q == ST_SETTLE && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end

            if (capture) begin
                resp_class_q <= bus.core_prediction;
                resp_valid_q <= 1'b1;
            end

            if (handshake) begin
                resp_valid_q <= 1'b0;
                done_cnt_q   <= done_cnt_q + 16'd1;
            end
        end
    end

    assign bus.req_ready     = req_ready_d;
    assign bus.core_features = core_features_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_id       = resp_id_q;
    assign bus.resp_class    = resp_class_q;
    assign bus.done_cnt      = done_cnt_q;

endmodule

// File: doc/winewhite_bnn_sched.md
WINEWHITE_BNN_SCHED -- requirements
Module: winewhite_bnn_sched

Interface
REQ-001 Parameter FEAT_CNT, default 11, SHALL be the number of features per vector.
REQ-002 Parameter FEAT_BITS, default 4, SHALL be the bits per feature.
REQ-003 Parameter CLASS_CNT, default 7, SHALL be the number of classes; CW = $clog2(CLASS_CNT).
REQ-004 Parameter REQ_CNT, default 2, SHALL be the number of requesters; IW = $clog2(REQ_CNT), and REQ_CNT SHALL be at least 2.
REQ-005 Parameter SETTLE_CYC, default 2, SHALL be the core settle time in clk cycles, at least 1.
REQ-006 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-008 req_valid  input  REQ_CNT  SHALL be the per-requester request valid.
REQ-009 req_ready  output  REQ_CNT  SHALL be the per-requester accept, one-hot or zero.
REQ-010 req_features  input  REQ_CNT*FEAT_CNT*FEAT_BITS  SHALL carry the packed vectors; requester r occupies slice r.
REQ-011 core_features  output  FEAT_CNT*FEAT_BITS  SHALL be the registered vector driven to the external combinational BNN core.
REQ-012 core_prediction  input  CW  SHALL be the core class output.
REQ-013 resp_valid  output  1  SHALL flag that a result is available.
REQ-014 resp_ready  input  1  SHALL be the consumer accept for the result.
REQ-015 resp_id  output  IW  SHALL identify the requester that owns the result.
REQ-016 resp_class  output  CW  SHALL carry the captured class.
REQ-017 done_cnt  output  16  SHALL count completed response handshakes and wrap from 0xFFFF to 0.

Function
REQ-018 The FSM SHALL have states IDLE, SETTLE and HOLD.
REQ-019 In IDLE, req_ready SHALL be asserted combinationally for exactly one requester: the first valid requester found scanning upward from (last_grant+1) mod REQ_CNT. Otherwise req_ready SHALL be 0.
REQ-020 Accept edge (IDLE with a grant):
- core_features <= granted slice
- resp_id <= grant index
- last_grant <= grant index
- cnt <= SETTLE_CYC-1
- state <= SETTLE
REQ-021 In SETTLE, cnt SHALL decrement each edge; on the edge where cnt==0 the block SHALL set resp_class <= core_prediction and resp_valid <= 1, and move to HOLD.
REQ-022 Latency SHALL be exactly SETTLE_CYC edges from the accept edge until resp_valid is high.
REQ-023 In HOLD, resp_valid, resp_id, resp_class and core_features SHALL remain stable until resp_valid&&resp_ready.
REQ-024 On the resp_valid&&resp_ready edge, the block SHALL clear resp_valid, increment done_cnt and return to IDLE. No new accept SHALL occur in that same cycle.
REQ-025 req_ready SHALL be 0 in SETTLE and HOLD. A requester deasserting valid before it is granted SHALL be legal and SHALL have no effect.
REQ-026 resp_ready asserted outside HOLD SHALL be ignored.
REQ-027 When only one requester is valid, it SHALL be granted regardless of last_grant.

Reset
REQ-028 On a rst edge the block SHALL set:
- state = IDLE
- req_ready = 0
- resp_valid = 0
- resp_id = 0
- resp_class = 0
- core_features = 0
- done_cnt = 0
- cnt = 0
- last_grant = REQ_CNT-1, so requester 0 has first priority
REQ-029 rst SHALL override all other activity, including mid-SETTLE and mid-HOLD. An in-flight request SHALL be dropped with no response.

Structure
REQ-030 The FSM state encoding and the default dataset parameters (FEAT_CNT, FEAT_BITS, CLASS_CNT) SHALL live in a shared package, bnn_sched_pkg.
REQ-031 Round-robin selection SHALL be a sub-module, rr_arbiter (inputs: request vector, last_grant; outputs: one-hot grant, index, any).
REQ-032 The BNN core SHALL be external to the block; a wrapper pairing the block with winewhite_bnn1_bnnparce SHALL be used in the bench.

Verification
REQ-033 Single request: after rst, req_valid=01 with features 0x123456789AB, then resp_ready=1 → accept at edge E0, resp_valid at E0+2, resp_id=0, resp_class equals the core output for that vector, done_cnt=1.
REQ-034 Contention: req_valid=11 held with resp_ready=1 → grants in order 0,1,0,1; every result matches its own slice; done_cnt=4 after four handshakes.
REQ-035 Backpressure: resp_ready=0 for 10 cycles in HOLD → resp_valid, resp_class and resp_id stay constant, req_ready=00, done_cnt unchanged; then resp_ready=1 → one handshake only.
REQ-036 Reset mid-SETTLE: rst pulsed one cycle after accept → resp_valid=0, core_features=0, state IDLE, done_cnt=0; the next req_valid=10 is granted to requester 1.
REQ-037 Full run: 1000 winewhite.memh vectors on requester 0 (SETTLE_CYC=2) → predictions identical to direct core evaluation; done_cnt=1000.
REQ-038 Counter wrap: done_cnt forced to 0xFFFF → next handshake yields done_cnt=0.
